pla_cube_eval: RTL and testbench

- Sequential, loadable sum-of-products evaluator for PLA-benchmark logic functions, generalised to N_IN inputs and N_OUT outputs.
- A cube table is written over a config port. Each input vector is then evaluated by scanning LANES cubes per cycle and OR-ing the output masks of the matching cubes.
- Lets the experiment harness run any benchmark function in hardware without re-synthesising a fixed combinational netlist.

---
 rtl/pla_pkg.sv | 34 +++
 rtl/pla_cube_lane.sv | 21 ++
 rtl/pla_cube_eval.sv | 127 ++++++++++++
 tb/tb_pla_cube_eval.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pla_pkg.sv
// rtl/pla_pkg.sv - shared types and helpers for the PLA cube evaluator
package pla_pkg;

   localparam int MAX_IN  = 32;
   localparam int MAX_OUT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [MAX_IN-1:0]  care;
      logic [MAX_IN-1:0]  val;
      logic [MAX_OUT-1:0] out;
   } cube_t;

   function automatic logic cube_match(input logic [MAX_IN-1:0] x,
                                       input logic [MAX_IN-1:0] care,
                                       input logic [MAX_IN-1:0] val);
      return ((x ^ val) & care) == '0;
   endfunction

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so a count or index equal to the depth does not wrap.
   function automatic int cnt_w(input int depth);
      return addr_w(depth) + 1;
   endfunction

endpackage

// File: rtl/pla_cube_lane.sv
// rtl/pla_cube_lane.sv - one cube comparator gated onto its output mask
module pla_cube_lane
   import pla_pkg::*;
#(
   parameter int N_IN  = 8,
   parameter int N_OUT = 1
) (
   input  logic             i_en,
   input  logic [N_IN-1:0]  i_x,
   input  logic [N_IN-1:0]  i_care,
   input  logic [N_IN-1:0]  i_val,
   input  logic [N_OUT-1:0] i_out,
   output logic [N_OUT-1:0] o_hit
);

   logic w_match;

   assign w_match = i_en && cube_match(MAX_IN'(i_x), MAX_IN'(i_care), MAX_IN'(i_val));
   assign o_hit   = w_match ? i_out : '0;

endmodule

// File: rtl/pla_cube_eval.sv
// rtl/pla_cube_eval.sv - loadable sum-of-products evaluator scanning LANES cubes per cycle
module pla_cube_eval
   import pla_pkg::*;
#(
   parameter int N_IN       = 8,
   parameter int N_OUT      = 1,
   parameter int DEPTH      = 64,
   parameter int LANES      = 1,
   parameter int EARLY_EXIT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic [N_IN-1:0]          cfg_care,
   input  logic [N_IN-1:0]          cfg_val,
   input  logic [N_OUT-1:0]         cfg_out,
   input  logic                     cfg_nact_we,
   input  logic [$clog2(DEPTH):0]   cfg_nact,
   output logic                     cfg_err,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_IN-1:0]          in_x,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_OUT-1:0]         out_y,
   output logic                     busy
);

   localparam int AW = addr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_LANES = CW'(LANES);

   state_t            r_state, w_state_nxt;
   logic [CW-1:0]     r_nact, r_idx, w_idx_nxt;
   logic [N_OUT-1:0]  r_acc, w_acc_nxt, w_hit_or;
   logic [N_IN-1:0]   r_x;
   logic              r_cfg_err;
   logic [N_IN-1:0]   r_care [DEPTH];
   logic [N_IN-1:0]   r_val  [DEPTH];
   logic [N_OUT-1:0]  r_out  [DEPTH];
   logic [N_OUT-1:0]  w_hit  [LANES];
   logic              w_idle, w_hs, w_cube_wr, w_nact_wr, w_err, w_scan_end;

   assign w_idle    = (r_state == IDLE);
   assign w_hs      = w_idle && in_valid;
   // A cube write racing a handshake is refused so the scan sees a frozen table.
   assign w_cube_wr = cfg_we && w_idle && !w_hs;
   assign w_nact_wr = cfg_nact_we && w_idle && (cfg_nact <= C_DEPTH);
   assign w_err     = (cfg_we && !w_cube_wr) || (cfg_nact_we && !w_nact_wr);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [CW-1:0] w_lidx;
      assign w_lidx = r_idx + CW'(g);
      pla_cube_lane #(.N_IN(N_IN), .N_OUT(N_OUT)) u_lane (
         .i_en   (w_lidx < r_nact),
         .i_x    (r_x),
         .i_care (r_care[w_lidx[AW-1:0]]),
         .i_val  (r_val[w_lidx[AW-1:0]]),
         .i_out  (r_out[w_lidx[AW-1:0]]),
         .o_hit  (w_hit[g])
      );
   end

   always_comb begin
      w_hit_or = '0;
      for (int l = 0; l < LANES; l++) w_hit_or = w_hit_or | w_hit[l];
   end

   assign w_acc_nxt  = r_acc | w_hit_or;
   assign w_idx_nxt  = r_idx + C_LANES;
   assign w_scan_end = (w_idx_nxt >= r_nact) || ((EARLY_EXIT != 0) && (&w_acc_nxt));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_hs) w_state_nxt = (r_nact == '0) ? DONE : SCAN;
         SCAN:    if (w_scan_end) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_nact    <= '0;
         r_idx     <= '0;
         r_acc     <= '0;
         r_x       <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cfg_err <= w_err;
         if (w_nact_wr) r_nact <= cfg_nact;
         case (r_state)
            IDLE: if (w_hs) begin
               r_x   <= in_x;
               r_acc <= '0;
               r_idx <= '0;
            end
            SCAN: begin
               r_acc <= w_acc_nxt;
               r_idx <= w_idx_nxt;
            end
            default: ;
         endcase
      end
   end

   // Table contents survive reset; nact=0 makes them unreachable.
   always_ff @(posedge clk) begin
      if (w_cube_wr) begin
         r_care[cfg_addr] <= cfg_care;
         r_val[cfg_addr]  <= cfg_val;
         r_out[cfg_addr]  <= cfg_out;
      end
   end

   assign in_ready  = w_idle;
   assign busy      = !w_idle;
   assign out_valid = (r_state == DONE);
   assign out_y     = r_acc;
   assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pla_cube_eval.sv
// tb/tb_pla_cube_eval.sv - randomized self-checking bench for pla_cube_eval
module tb_pla_cube_eval;
   import pla_pkg::*;

   localparam int N_IN = 8, N_OUT = 2, DEPTH = 64, LANES = 4, EARLY = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0, cfg_nact_we = 1'b0;
   logic [5:0] cfg_addr = '0;
   logic [7:0] cfg_care = '0, cfg_val = '0;
   logic [1:0] cfg_out = '0;
   logic [6:0] cfg_nact = '0;
   logic       cfg_err;
   logic       in_valid = 1'b0, in_ready;
   logic [7:0] in_x = '0;
   logic       out_valid, out_ready = 1'b0, busy;
   logic [1:0] out_y;

   pla_cube_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .LANES(LANES), .EARLY_EXIT(EARLY)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
      .cfg_val(cfg_val), .cfg_out(cfg_out), .cfg_nact_we(cfg_nact_we), .cfg_nact(cfg_nact),
      .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
   );

   always #5 clk = ~clk;

   cube_t m_tab [DEPTH];
   int    m_nact = 0;
   int    n_pass = 0, n_total = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cover model: walk the table in groups of LANES, stopping when all outputs are set.
   task automatic model(input logic [7:0] x, output logic [1:0] y, output int lat);
      int groups;
      y = '0;
      groups = 0;
      for (int base = 0; base < m_nact; base += LANES) begin
         groups++;
         for (int i = base; i < base + LANES && i < m_nact; i++)
            if (((x ^ m_tab[i].val[7:0]) & m_tab[i].care[7:0]) == 8'h00)
               y = y | m_tab[i].out[1:0];
         if (EARLY != 0 && y == 2'b11) break;
      end
      lat = groups + 1;
   endtask

   task automatic write_cube(input int a, input logic [7:0] c, input logic [7:0] v, input logic [1:0] o);
      cfg_we = 1'b1; cfg_addr = 6'(a); cfg_care = c; cfg_val = v; cfg_out = o;
      tick();
      cfg_we = 1'b0;
      chk("wr_err", cfg_err, 0);
      m_tab[a] = '{care: 32'(c), val: 32'(v), out: 16'(o)};
   endtask

   task automatic set_nact(input int n);
      cfg_nact_we = 1'b1; cfg_nact = 7'(n);
      tick();
      cfg_nact_we = 1'b0;
      chk("nact_err", cfg_err, (n > DEPTH) ? 1 : 0);
      if (n <= DEPTH) m_nact = n;
   endtask

   task automatic eval(input logic [7:0] x, input int hold, input bit clash, input string tag);
      logic [1:0] ey;
      int elat, lat;
      model(x, ey, elat);
      chk({tag, "_rdy"}, in_ready, 1);
      in_valid = 1'b1; in_x = x;
      if (clash) begin
         cfg_we = 1'b1; cfg_addr = 6'd0;
         cfg_care = ~m_tab[0].care[7:0]; cfg_val = ~m_tab[0].val[7:0]; cfg_out = ~m_tab[0].out[1:0];
      end
      tick();
      in_valid = 1'b0; cfg_we = 1'b0;
      if (clash) chk({tag, "_clash_err"}, cfg_err, 1);
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_y"}, out_y, ey);
      for (int k = 0; k < hold; k++) begin
         if (k == 3) begin
            cfg_we = 1'b1; cfg_addr = 6'd0; cfg_care = 8'hFF; cfg_val = 8'h00; cfg_out = 2'b00;
         end
         if (k == 6) begin
            cfg_nact_we = 1'b1; cfg_nact = 7'd1;
         end
         tick();
         cfg_we = 1'b0; cfg_nact_we = 1'b0;
         chk({tag, "_bp_err"}, cfg_err, (k == 3 || k == 6) ? 1 : 0);
         chk({tag, "_bp_valid"}, out_valid, 1);
         chk({tag, "_bp_y"}, out_y, ey);
         chk({tag, "_bp_rdy"}, in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_done_valid"}, out_valid, 0);
      chk({tag, "_done_rdy"}, in_ready, 1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
      repeat (2) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      rst = 1'b0;
      tick();

      eval(8'hA5, 0, 1'b0, "empty");

      write_cube(0, 8'h0C, 8'h04, 2'b01);
      set_nact(1);
      eval(8'h34, 0, 1'b0, "one_hit");
      eval(8'h38, 0, 1'b0, "one_miss");

      for (int i = 0; i < 4; i++) write_cube(i, 8'hFF, 8'(i + 1), 2'b01);
      write_cube(4, 8'hF0, 8'hF0, 2'b01);
      set_nact(5);
      eval(8'hF0, 0, 1'b0, "scan_last");
      eval(8'h00, 0, 1'b0, "scan_none");

      write_cube(0, 8'h00, 8'h00, 2'b11);
      for (int i = 5; i < 9; i++) write_cube(i, 8'hFF, 8'h55, 2'b10);
      set_nact(9);
      eval(8'h12, 0, 1'b0, "early");
      eval(8'h12, 0, 1'b1, "clash");
      eval(8'hF0, 10, 1'b0, "bp");
      eval(8'h77, 0, 1'b0, "bp_after");

      write_cube(0, 8'hFF, 8'h01, 2'b01);
      in_valid = 1'b1; in_x = 8'h00;
      tick();
      in_valid = 1'b0;
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", out_valid, 0);
      tick();
      rst = 1'b0;
      m_nact = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("post_rst_valid", out_valid, 0);
      end
      eval(8'h00, 0, 1'b0, "post_rst");

      for (int i = 0; i < 40; i++)
         write_cube(i, 8'($urandom & $urandom & $urandom), 8'($urandom), 2'($urandom_range(1, 3)));
      set_nact(40);
      for (int x = 0; x < 256; x++) eval(8'(x), 0, 1'b0, "sweep");
      set_nact(65);
      for (int k = 0; k < 16; k++) eval(8'($urandom), 0, 1'b0, "after65");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
